// File: rtl/jtdsp16_sio_tx.sv
// jtdsp16_sio_tx: DSP16 serial output port, SDX holding register feeding a 16-bit shifter
// Ports: rst/clk/cen (async reset, clock, clock enable); sdx_wr/sdx_din write SDX;
// len8/msb_first/clkdiv set frame length, bit order and bit period 2^(clkdiv+2);
// ock/sdo/ose are the serial clock, data and first-bit sync; obe = SDX empty; busy = shifting.
module jtdsp16_sio_tx #(
  parameter int DIVW = 5
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic        sdx_wr,
  input  logic [15:0] sdx_din,
  input  logic        len8,
  input  logic        msb_first,
  input  logic [1:0]  clkdiv,
  output logic        ock,
  output logic        sdo,
  output logic        ose,
  output logic        obe,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t state_q, state_d;
  logic [15:0] sdx_q, sdx_d, shr_q, shr_d;
  logic full_q, full_d, len8_q, len8_d, msbf_q, msbf_d;
  logic [3:0] cnt_q, cnt_d;
  logic [DIVW-1:0] pre_q, pre_d, tc_v, half_v;
  logic [1:0] div_q, div_d;
  logic tc;
  // the divider in use is resampled only at LOAD and at each prescaler wrap
  assign tc_v   = DIVW'((32'd4 << div_q) - 32'd1);
  assign half_v = DIVW'(32'd2 << div_q);
  assign tc     = pre_q == tc_v;
  always_comb begin
    state_d = state_q;
    sdx_d   = sdx_q;
    full_d  = full_q;
    shr_d   = shr_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    div_d   = div_q;
    len8_d  = len8_q;
    msbf_d  = msbf_q;
    if (cen) begin
      case (state_q)
        IDLE: state_d = full_q ? LOAD : IDLE;
        LOAD: begin
          shr_d   = sdx_q;
          full_d  = 1'b0;
          cnt_d   = len8 ? 4'd7 : 4'd15;
          pre_d   = '0;
          div_d   = clkdiv;
          len8_d  = len8;
          msbf_d  = msb_first;
          state_d = SHIFT;
        end
        SHIFT: begin
          pre_d = tc ? '0 : pre_q + DIVW'(1);
          if (tc) begin
            shr_d   = msbf_q ? shr_q << 1 : shr_q >> 1;
            cnt_d   = cnt_q - 4'd1;
            div_d   = clkdiv;
            state_d = cnt_q == 4'd0 ? (full_q ? LOAD : IDLE) : SHIFT;
          end
        end
        default: state_d = IDLE;
      endcase
      // a write on the LOAD tick keeps SDX full with the new word
      if (sdx_wr) begin
        sdx_d  = sdx_din;
        full_d = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sdx_q   <= '0;
      full_q  <= 1'b0;
      shr_q   <= '0;
      cnt_q   <= '0;
      pre_q   <= '0;
      div_q   <= '0;
      len8_q  <= 1'b0;
      msbf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sdx_q   <= sdx_d;
      full_q  <= full_d;
      shr_q   <= shr_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      div_q   <= div_d;
      len8_q  <= len8_d;
      msbf_q  <= msbf_d;
    end
  end
  assign busy = state_q == SHIFT;
  assign obe  = !full_q;
  assign ock  = busy && pre_q >= half_v;
  assign sdo  = busy && (msbf_q ? (len8_q ? shr_q[7] : shr_q[15]) : shr_q[0]);
  assign ose  = busy && cnt_q == (len8_q ? 4'd7 : 4'd15);
endmodule
